// File: rtl/ram_weights_seq.sv
// ram_weights_seq: fills a single-port weight SRAM from an AXI-stream, then
// replays the stored words out of a second AXI-stream a configurable number
// of times.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   s_valid/s_ready/s_data/s_last  fill stream; s_ready high in FILL only
//   cfg_passes                 replay count, sampled on the final fill beat
//   m_valid/m_ready/m_data/m_last  drain stream; m_last on final word only
//   ram_en/ram_we/ram_addr/ram_din/ram_dout  SRAM master, 1-cycle read latency
//   busy                       high while draining
`ifndef RAM_WEIGHTS_DEPTH
`define RAM_WEIGHTS_DEPTH 16
`endif
`ifndef COLS
`define COLS 4
`endif
`ifndef K_BITS
`define K_BITS 8
`endif

module ram_weights_seq #(
  parameter int DEPTH     = `RAM_WEIGHTS_DEPTH,
  parameter int WIDTH     = `COLS*`K_BITS,
  parameter int PASS_BITS = 8,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic [PASS_BITS-1:0] cfg_passes,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [WIDTH-1:0]     ram_din,
  input  logic [WIDTH-1:0]     ram_dout,
  output logic                 busy
);

  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [PASS_BITS-1:0] passes, pass_cnt;
  logic                 rd_done;
  logic                 inflight, inflight_last;
  logic [WIDTH-1:0]     fifo_data [2];
  logic                 fifo_last [2];
  logic                 wr_idx, rd_idx;
  logic [1:0]           occ;

  logic accept, fill_end, issue, pop, rd_wrap, final_rd, room;

  assign rd_wrap  = ({1'b0, rd_ptr} == count - 1'b1);
  assign final_rd = rd_wrap && (pass_cnt == passes - 1'b1);
  // A slot freed by this cycle's pop is reusable by this cycle's read: the
  // data lands two edges later, after the pop has retired. This is what
  // allows one beat per cycle with only two FIFO entries.
  assign room = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    accept    = 1'b0;
    fill_end  = 1'b0;
    issue     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    m_valid   = (occ != 2'd0);
    pop       = m_valid && m_ready;
    m_data    = m_valid ? fifo_data[rd_idx] : '0;
    m_last    = m_valid && fifo_last[rd_idx];
    busy      = (state == DRAIN);
    if (!rst) begin
      case (state)
        FILL: begin
          s_ready  = 1'b1;
          accept   = s_valid;
          fill_end = accept && (s_last || wr_ptr == AW'(DEPTH - 1));
          if (accept) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_ptr;
            ram_din  = s_data;
          end
          if (fill_end) state_nxt = DRAIN;
        end
        DRAIN: begin
          issue = !rd_done && room;
          if (issue) begin
            ram_en   = 1'b1;
            ram_addr = rd_ptr;
          end
          if (pop && m_last) state_nxt = FILL;
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      passes        <= '0;
      pass_cnt      <= '0;
      rd_done       <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_idx        <= 1'b0;
      rd_idx        <= 1'b0;
      occ           <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (accept) wr_ptr <= fill_end ? '0 : wr_ptr + 1'b1;
      if (fill_end) begin
        count    <= {1'b0, wr_ptr} + 1'b1;
        passes   <= (cfg_passes == '0) ? PASS_BITS'(1) : cfg_passes;
        rd_ptr   <= '0;
        pass_cnt <= '0;
        rd_done  <= 1'b0;
      end
      if (issue) begin
        if (rd_wrap) begin
          rd_ptr <= '0;
          if (final_rd) rd_done  <= 1'b1;
          else          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      // ram_dout is only meaningful the cycle after a read was issued
      inflight      <= issue;
      inflight_last <= issue && final_rd;
      if (inflight) begin
        fifo_data[wr_idx] <= ram_dout;
        fifo_last[wr_idx] <= inflight_last;
        wr_idx            <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
